// File: rtl/n64_vbus_demux_pkg.sv
// n64_vbus_demux_pkg: shared widths, sync bit positions and FSM encoding for the video bus demux
package n64_vbus_demux_pkg;
   localparam int COLOR_W             = 7;
   localparam int VDATA_W             = 4 + 3*COLOR_W;
   localparam int NVS                 = 3;
   localparam int NCLAMP              = 2;
   localparam int NHS                 = 1;
   localparam int NCS                 = 0;
   localparam int PAL_LINE_THRESH_DEF = 290;
   localparam logic [3:0] SYNC_IDLE   = 4'((1 << NVS) | (1 << NCLAMP) | (1 << NHS) | (1 << NCS));
   typedef enum logic [2:0] {WAIT, SYN, RED, GRN, BLU} state_e;
endpackage

// File: rtl/n64_vbus_demux_if.sv
// n64_vbus_demux_if: N64 multiplexed video bus, nDSYNC plus the shared sync/colour word
interface n64_vbus_demux_if;
   import n64_vbus_demux_pkg::*;
   logic               nDSYNC;
   logic [COLOR_W-1:0] D_i;
   modport master (output nDSYNC, D_i);
   modport slave  (input nDSYNC, D_i);
endinterface

// File: rtl/n64_field_detect.sv
// n64_field_detect: counts lines per field on locked pixels and derives PAL / interlaced flags
module n64_field_detect
   import n64_vbus_demux_pkg::*;
#(
   parameter int PAL_LINE_THRESH = PAL_LINE_THRESH_DEF,
   parameter int LCNT_W          = 10
) (
   input  logic       VCLK,
   input  logic       nRST,
   input  logic       strobe_i,
   input  logic       lock_i,
   input  logic       nvs_i,
   input  logic       nhs_i,
   output logic [1:0] vinfo_o
);
   logic [LCNT_W-1:0] lcnt_q, lcnt_d;
   logic              pvs_q, phs_q, fid_q, fid_d, pal_q, pal_d, il_q, il_d;
   logic              run, vs_fall, hs_fall;

   assign run     = strobe_i && lock_i;
   assign vs_fall = pvs_q && !nvs_i;
   assign hs_fall = phs_q && !nhs_i;
   assign vinfo_o = {pal_q, il_q};

   // nVS fall closes a field; a coincident nHS fall marks the field id instead of counting a line
   always_comb begin
      lcnt_d = lock_i ? lcnt_q : '0;
      fid_d  = fid_q;
      pal_d  = pal_q;
      il_d   = il_q;
      if (run && vs_fall) begin
         lcnt_d = '0;
         pal_d  = int'(lcnt_q) >= PAL_LINE_THRESH;
         fid_d  = hs_fall;
         il_d   = hs_fall != fid_q;
      end else if (run && hs_fall && lcnt_q != '1)
         lcnt_d = lcnt_q + 1'b1;
   end

   // field state, plus previous pixel's nVS/nHS tracked on every strobe
   always_ff @(posedge VCLK or negedge nRST)
      if (!nRST) begin
         lcnt_q <= '0;
         pvs_q  <= 1'b1;
         phs_q  <= 1'b1;
         fid_q  <= 1'b0;
         pal_q  <= 1'b0;
         il_q   <= 1'b0;
      end else begin
         lcnt_q <= lcnt_d;
         fid_q  <= fid_d;
         pal_q  <= pal_d;
         il_q   <= il_d;
         if (strobe_i) begin
            pvs_q <= nvs_i;
            phs_q <= nhs_i;
         end
      end
endmodule

// File: rtl/n64_vbus_demux.sv
// n64_vbus_demux: decodes the N64 nDSYNC/D bus into parallel pixel words with lock and field info
module n64_vbus_demux
   import n64_vbus_demux_pkg::*;
#(
   parameter int LOCK_PIX        = 4,
   parameter int PAL_LINE_THRESH = PAL_LINE_THRESH_DEF,
   parameter int LCNT_W          = 10
) (
   input  logic               VCLK,
   input  logic               nRST,
   n64_vbus_demux_if.slave    vbus,
   output logic [VDATA_W-1:0] vdata_o,
   output logic               pix_valid_o,
   output logic               lock_o,
   output logic [1:0]         vinfo_o
);
   localparam int GW = $clog2(LOCK_PIX + 1);

   logic               nds_q;
   logic [COLOR_W-1:0] d_q;
   state_e             st_q, st_d;
   logic [3:0]         sync_q, sync_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic [GW-1:0]      gcnt_q, gcnt_d;
   logic [VDATA_W-1:0] vdata_q, vdata_d;
   logic               pv_q, emit, perr;

   assign gcnt_d      = perr ? '0 : (emit && !lock_o) ? gcnt_q + 1'b1 : gcnt_q;
   assign vdata_d     = emit ? {sync_q, r_q, g_q, b_q} : vdata_q;
   assign lock_o      = gcnt_q == GW'(LOCK_PIX);
   assign vdata_o     = vdata_q;
   assign pix_valid_o = pv_q;

   // stage the raw bus once; idle nDSYNC high so reset never looks like a sync word
   always_ff @(posedge VCLK or negedge nRST)
      if (!nRST) begin
         nds_q <= 1'b1;
         d_q   <= '0;
      end else begin
         nds_q <= vbus.nDSYNC;
         d_q   <= vbus.D_i;
      end

   // any sync word restarts the pixel; it completes a pixel only when it follows BLU
   always_comb begin
      st_d   = st_q;
      sync_d = sync_q;
      r_d    = r_q;
      g_d    = g_q;
      b_d    = b_q;
      emit   = 1'b0;
      perr   = 1'b0;
      if (!nds_q) begin
         st_d   = SYN;
         sync_d = d_q[3:0];
         emit   = st_q == BLU;
         perr   = st_q == RED || st_q == GRN;
      end else begin
         case (st_q)
            SYN:     begin st_d = RED;  r_d = d_q; end
            RED:     begin st_d = GRN;  g_d = d_q; end
            GRN:     begin st_d = BLU;  b_d = d_q; end
            BLU:     begin st_d = WAIT; perr = 1'b1; end
            default: st_d = WAIT;
         endcase
      end
   end

   // FSM, hold registers, output word and good-pixel counter
   always_ff @(posedge VCLK or negedge nRST)
      if (!nRST) begin
         st_q    <= WAIT;
         sync_q  <= SYNC_IDLE;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         gcnt_q  <= '0;
         vdata_q <= {SYNC_IDLE, {(3*COLOR_W){1'b0}}};
         pv_q    <= 1'b0;
      end else begin
         st_q    <= st_d;
         sync_q  <= sync_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         gcnt_q  <= gcnt_d;
         vdata_q <= vdata_d;
         pv_q    <= emit;
      end

   n64_field_detect #(.PAL_LINE_THRESH(PAL_LINE_THRESH), .LCNT_W(LCNT_W)) u_fd (
      .VCLK     (VCLK),
      .nRST     (nRST),
      .strobe_i (pix_valid_o),
      .lock_i   (lock_o),
      .nvs_i    (vdata_o[VDATA_W-4+NVS]),
      .nhs_i    (vdata_o[VDATA_W-4+NHS]),
      .vinfo_o  (vinfo_o)
   );
endmodule

// File: tb/tb_n64_vbus_demux.sv
// tb_n64_vbus_demux: directed tables and random bus traffic against a word-stream reference model
module tb_n64_vbus_demux;
   import n64_vbus_demux_pkg::*;

   logic               VCLK = 1'b0;
   logic               nRST = 1'b0;
   logic [VDATA_W-1:0] vdata_o;
   logic               pix_valid_o, lock_o;
   logic [1:0]         vinfo_o;

   n64_vbus_demux_if bus();

   n64_vbus_demux dut (
      .VCLK        (VCLK),
      .nRST        (nRST),
      .vbus        (bus),
      .vdata_o     (vdata_o),
      .pix_valid_o (pix_valid_o),
      .lock_o      (lock_o),
      .vinfo_o     (vinfo_o)
   );

   always #5 VCLK = ~VCLK;

   int n_chk = 0;
   int n_pass = 0;

   // reference model: run_m = colour words seen since the last sync word (-1 = none/idle)
   int                 run_m, good_m, lines_m;
   logic [3:0]         sync_m;
   logic [6:0]         col_m [3];
   logic               pvs_m, phs_m, fid_m, pal_m, il_m;
   logic               pend_v, pend_ds;
   logic [6:0]         pend_d;
   logic               exp_pv, exp_lock;
   logic [1:0]         exp_vinfo, vinfo_nxt;
   logic [VDATA_W-1:0] exp_vdata;

   typedef struct {
      logic               ds;
      logic [6:0]         d;
      logic               pv;
      logic               lock;
      logic [VDATA_W-1:0] vd;
   } vec_t;
   vec_t tbl [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      run_m = -1; good_m = 0; lines_m = 0; sync_m = 4'hF;
      col_m[0] = '0; col_m[1] = '0; col_m[2] = '0;
      pvs_m = 1'b1; phs_m = 1'b1; fid_m = 1'b0; pal_m = 1'b0; il_m = 1'b0;
      pend_v = 1'b0; pend_ds = 1'b1; pend_d = '0;
      exp_pv = 1'b0; exp_lock = 1'b0; exp_vinfo = 2'b00; vinfo_nxt = 2'b00;
      exp_vdata = {4'hF, 21'h0};
   endtask

   task automatic field_step(input logic [3:0] s);
      logic vf, hf;
      vf = pvs_m && !s[3];
      hf = phs_m && !s[1];
      pvs_m = s[3];
      phs_m = s[1];
      if (good_m != 4) lines_m = 0;
      else if (vf) begin
         pal_m = lines_m >= 290;
         il_m = hf != fid_m;
         fid_m = hf;
         lines_m = 0;
      end else if (hf && lines_m < 1023) lines_m++;
      vinfo_nxt = {pal_m, il_m};
   endtask

   task automatic model_step();
      exp_vinfo = vinfo_nxt;
      exp_pv = 1'b0;
      if (pend_v) begin
         if (!pend_ds) begin
            if (run_m == 3) begin
               exp_pv = 1'b1;
               exp_vdata = {sync_m, col_m[0], col_m[1], col_m[2]};
               good_m = good_m < 4 ? good_m + 1 : 4;
               field_step(sync_m);
            end else if (run_m == 1 || run_m == 2) good_m = 0;
            sync_m = pend_d[3:0];
            run_m = 0;
         end else begin
            if (run_m == 3) good_m = 0;
            if (run_m >= 0 && run_m < 3) col_m[run_m] = pend_d;
            run_m = (run_m >= 0 && run_m < 4) ? run_m + 1 : -1;
         end
      end
      exp_lock = good_m == 4;
   endtask

   task automatic cyc(input logic ds, input logic [6:0] d);
      bus.nDSYNC = ds;
      bus.D_i = d;
      @(posedge VCLK);
      model_step();
      pend_v = 1'b1; pend_ds = ds; pend_d = d;
      @(negedge VCLK);
      check("pix_valid", pix_valid_o, exp_pv);
      check("lock", lock_o, exp_lock);
      check("vinfo", vinfo_o, exp_vinfo);
      check("vdata", vdata_o, exp_vdata);
   endtask

   task automatic pix(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
      cyc(1'b0, {3'b000, s});
      cyc(1'b1, r);
      cyc(1'b1, g);
      cyc(1'b1, b);
   endtask

   task automatic field(input int n, input logic hs_on_vs);
      for (int l = 0; l < n; l++) begin
         pix(4'hF, 7'($urandom), 7'($urandom), 7'($urandom));
         pix(4'hD, 7'($urandom), 7'($urandom), 7'($urandom));
      end
      pix(4'hF, 7'h01, 7'h02, 7'h03);
      pix({1'b0, 1'b1, !hs_on_vs, 1'b1}, 7'h04, 7'h05, 7'h06);
   endtask

   initial begin
      int   strobes;
      logic ds;
      bus.nDSYNC = 1'b1;
      bus.D_i = '0;
      model_reset();
      repeat (2) @(negedge VCLK);
      check("rst_vdata", vdata_o, {4'hF, 21'h0});
      check("rst_pv", pix_valid_o, 1'b0);
      check("rst_lock", lock_o, 1'b0);
      check("rst_vinfo", vinfo_o, 2'b00);
      nRST = 1'b1;

      for (int i = 0; i < 20; i++) begin
         tbl[i].ds   = (i % 4) != 0;
         tbl[i].d    = (i % 4 == 0) ? 7'h0F : 7'(17 * (i % 4));
         tbl[i].pv   = i >= 5 && (i - 5) % 4 == 0;
         tbl[i].lock = i >= 17;
         tbl[i].vd   = i >= 5 ? {4'hF, 7'h11, 7'h22, 7'h33} : {4'hF, 21'h0};
      end
      for (int i = 0; i < 20; i++) begin
         cyc(tbl[i].ds, tbl[i].d);
         check("t1_pv", pix_valid_o, tbl[i].pv);
         check("t1_lock", lock_o, tbl[i].lock);
         check("t1_vdata", vdata_o, tbl[i].vd);
      end

      cyc(1'b0, 7'h0F);
      cyc(1'b1, 7'h11);
      cyc(1'b1, 7'h22);
      cyc(1'b0, 7'h0F);
      cyc(1'b1, 7'h11);
      check("t2_drop", lock_o, 1'b0);
      cyc(1'b1, 7'h22);
      cyc(1'b1, 7'h33);
      repeat (3) pix(4'hF, 7'h11, 7'h22, 7'h33);
      check("t2_still_unlocked", lock_o, 1'b0);
      pix(4'hF, 7'h11, 7'h22, 7'h33);
      check("t2_relock", lock_o, 1'b1);

      strobes = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 7'h55);
         strobes += int'(pix_valid_o);
      end
      check("t3_no_strobe", strobes, 0);
      check("t3_lock", lock_o, 1'b0);
      repeat (5) pix(4'hF, 7'h0A, 7'h0B, 7'h0C);
      check("t3_relock", lock_o, 1'b1);

      repeat (3) field(263, 1'b0);
      pix(4'hF, 7'h01, 7'h01, 7'h01);
      check("t4_ntsc_prog", vinfo_o, 2'b00);
      repeat (3) field(313, 1'b0);
      pix(4'hF, 7'h01, 7'h01, 7'h01);
      check("t4_pal_prog", vinfo_o, 2'b10);

      field(262, 1'b1);
      field(263, 1'b0);
      field(262, 1'b1);
      field(263, 1'b0);
      pix(4'hF, 7'h01, 7'h01, 7'h01);
      check("t5_interlaced", vinfo_o, 2'b01);

      cyc(1'b0, 7'h0F);
      cyc(1'b1, 7'h11);
      cyc(1'b1, 7'h22);
      #2 nRST = 1'b0;
      model_reset();
      #1;
      check("t6_rst_vdata", vdata_o, {4'hF, 21'h0});
      check("t6_rst_pv", pix_valid_o, 1'b0);
      check("t6_rst_lock", lock_o, 1'b0);
      check("t6_rst_vinfo", vinfo_o, 2'b00);
      @(negedge VCLK);
      nRST = 1'b1;
      strobes = 0;
      cyc(1'b1, 7'h33); strobes += int'(pix_valid_o);
      cyc(1'b0, 7'h0F); strobes += int'(pix_valid_o);
      cyc(1'b1, 7'h11); strobes += int'(pix_valid_o);
      cyc(1'b1, 7'h22); strobes += int'(pix_valid_o);
      cyc(1'b1, 7'h33); strobes += int'(pix_valid_o);
      cyc(1'b0, 7'h0F); strobes += int'(pix_valid_o);
      check("t6_no_early_strobe", strobes, 0);
      cyc(1'b1, 7'h11);
      check("t6_first_strobe", pix_valid_o, 1'b1);
      check("t6_first_vdata", vdata_o, {4'hF, 7'h11, 7'h22, 7'h33});

      for (int i = 0; i < 3000; i++) begin
         ds = (i % 4) != 0;
         if ($urandom_range(0, 31) == 0) ds = !ds;
         cyc(ds, 7'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
